// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address-field helpers for the data cache.
// Optional feature macro used by dcache_responder: DCACHE_PERF_CNT_EN.
package dcache_pkg;

  localparam int unsigned DCACHE_LINE_ADDR_LEN = 3;
  localparam int unsigned DCACHE_SET_ADDR_LEN  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2
  } dcache_state_e;

  // Tag field: everything above the set index.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                           input int unsigned line_len,
                                           input int unsigned set_len);
    return addr >> (2 + line_len + set_len);
  endfunction

  // Set index field.
  function automatic logic [31:0] addr_set(input logic [31:0] addr,
                                           input int unsigned line_len,
                                           input int unsigned set_len);
    return (addr >> (2 + line_len)) & ((32'd1 << set_len) - 32'd1);
  endfunction

  // Word-within-line field.
  function automatic logic [31:0] addr_word(input logic [31:0] addr,
                                            input int unsigned line_len);
    return (addr >> 2) & ((32'd1 << line_len) - 32'd1);
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data arrays of the direct-mapped cache.
// One set is addressed per cycle; two word read ports (CPU word, writeback word)
// and one byte-enabled word write port shared by CPU stores and refills.
module dcache_line_store import dcache_pkg::*; #(
  parameter int unsigned LINE_ADDR_LEN = DCACHE_LINE_ADDR_LEN,
  parameter int unsigned SET_ADDR_LEN  = DCACHE_SET_ADDR_LEN,
  localparam int unsigned TAG_W        = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [SET_ADDR_LEN-1:0]  set_i,
  input  logic [LINE_ADDR_LEN-1:0] rd_word_i,
  input  logic [LINE_ADDR_LEN-1:0] wb_word_i,
  input  logic [LINE_ADDR_LEN-1:0] wr_word_i,
  input  logic [3:0]               wr_be_i,
  input  logic [31:0]              wr_data_i,
  input  logic                     tag_we_i,
  input  logic [TAG_W-1:0]         tag_i,
  input  logic                     dirty_set_i,
  input  logic                     dirty_clr_i,
  output logic [31:0]              rd_word_c_o,
  output logic [31:0]              wb_word_c_o,
  output logic [TAG_W-1:0]         tag_c_o,
  output logic                     valid_c_o,
  output logic                     dirty_c_o
);

  localparam int unsigned SETS  = 1 << SET_ADDR_LEN;
  localparam int unsigned WORDS = 1 << LINE_ADDR_LEN;

  logic [31:0]      data_q [SETS*WORDS];
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;

  // Line state flags; reset invalidates every line and drops dirty data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (tag_we_i) valid_q[set_i] <= 1'b1;
      if (dirty_set_i) dirty_q[set_i] <= 1'b1;
      else if (dirty_clr_i) dirty_q[set_i] <= 1'b0;
    end
  end

  // Data and tag arrays are plain storage without reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be_i[b]) data_q[{set_i, wr_word_i}][8*b +: 8] <= wr_data_i[8*b +: 8];
    end
    if (tag_we_i) tag_q[set_i] <= tag_i;
  end

  assign rd_word_c_o = data_q[{set_i, rd_word_i}];
  assign wb_word_c_o = data_q[{set_i, wb_word_i}];
  assign tag_c_o     = tag_q[set_i];
  assign valid_c_o   = valid_q[set_i];
  assign dirty_c_o   = dirty_q[set_i];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache for the MEM stage.
// Misses stall the core via `miss` while lines are written back / refilled
// one word at a time over a req/ack memory handshake.
// Optional: define DCACHE_PERF_CNT_EN to add hit_cnt/miss_cnt outputs.
module dcache_responder import dcache_pkg::*; #(
  parameter int unsigned LINE_ADDR_LEN = DCACHE_LINE_ADDR_LEN,
  parameter int unsigned SET_ADDR_LEN  = DCACHE_SET_ADDR_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int unsigned TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;

  logic [TAG_ADDR_LEN-1:0]  req_tag, line_tag_q, ls_tag;
  logic [SET_ADDR_LEN-1:0]  req_set, line_set_q, cur_set;
  logic [LINE_ADDR_LEN-1:0] req_word, cnt_q, cnt_d, wb_idx, ls_wr_word;
  logic [31:0]              ls_rd_word, ls_wb_word, ls_wr_data;
  logic [3:0]               ls_wr_be;
  logic                     ls_valid, ls_dirty, ls_tag_we, ls_dirty_set, ls_dirty_clr;
  logic                     req, hit, ack, last;
  dcache_state_e            state_q;
  logic [31:0]              rd_data_q, mem_addr_q, mem_wdata_q;
  logic                     mem_req_q, mem_we_q;

  assign req_tag  = TAG_ADDR_LEN'(addr_tag(addr, LINE_ADDR_LEN, SET_ADDR_LEN));
  assign req_set  = SET_ADDR_LEN'(addr_set(addr, LINE_ADDR_LEN, SET_ADDR_LEN));
  assign req_word = LINE_ADDR_LEN'(addr_word(addr, LINE_ADDR_LEN));

  // The line address is captured at miss start so the transfer finishes
  // coherently even if the core drops its request mid-miss.
  assign cur_set = (state_q == ST_IDLE) ? req_set : line_set_q;
  assign req     = rd_req | wr_req;
  assign hit     = ls_valid && (ls_tag == req_tag);
  assign miss    = req && ((state_q != ST_IDLE) || !hit);
  assign ack     = mem_req_q && mem_ack;
  assign last    = (cnt_q == {LINE_ADDR_LEN{1'b1}});
  assign cnt_d   = cnt_q + LINE_ADDR_LEN'(1);
  assign wb_idx  = (state_q == ST_IDLE) ? '0 : cnt_d;

  dcache_line_store #(
    .LINE_ADDR_LEN(LINE_ADDR_LEN),
    .SET_ADDR_LEN (SET_ADDR_LEN)
  ) u_store (
    .clk_i       (clk),
    .rst_i       (rst),
    .set_i       (cur_set),
    .rd_word_i   (req_word),
    .wb_word_i   (wb_idx),
    .wr_word_i   (ls_wr_word),
    .wr_be_i     (ls_wr_be),
    .wr_data_i   (ls_wr_data),
    .tag_we_i    (ls_tag_we),
    .tag_i       (line_tag_q),
    .dirty_set_i (ls_dirty_set),
    .dirty_clr_i (ls_dirty_clr),
    .rd_word_c_o (ls_rd_word),
    .wb_word_c_o (ls_wb_word),
    .tag_c_o     (ls_tag),
    .valid_c_o   (ls_valid),
    .dirty_c_o   (ls_dirty)
  );

  // Array write strobes: CPU store on an idle hit, refill word on each fill ack.
  always_comb begin
    ls_wr_be     = 4'h0;
    ls_wr_word   = req_word;
    ls_wr_data   = wr_data;
    ls_tag_we    = 1'b0;
    ls_dirty_set = 1'b0;
    ls_dirty_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_req && hit) begin
          ls_wr_be     = wr_be;
          ls_dirty_set = |wr_be;
        end
      end
      ST_WB: ls_dirty_clr = ack && last;
      ST_FILL: begin
        if (ack) begin
          ls_wr_be   = 4'hF;
          ls_wr_word = cnt_q;
          ls_wr_data = mem_rdata;
          ls_tag_we  = last;
        end
      end
      default: ;
    endcase
  end

  // Miss FSM with registered memory handshake and load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      line_tag_q  <= '0;
      line_set_q  <= '0;
      rd_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req && hit) begin
            if (rd_req && !wr_req) rd_data_q <= ls_rd_word;
          end else if (req) begin
            line_tag_q <= req_tag;
            line_set_q <= req_set;
            cnt_q      <= '0;
            mem_req_q  <= 1'b1;
            if (ls_valid && ls_dirty) begin
              state_q     <= ST_WB;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {ls_tag, req_set, {LINE_ADDR_LEN{1'b0}}, 2'b00};
              mem_wdata_q <= ls_wb_word;
            end else begin
              state_q    <= ST_FILL;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {req_tag, req_set, {LINE_ADDR_LEN{1'b0}}, 2'b00};
            end
          end
        end
        ST_WB: begin
          if (ack) begin
            if (last) begin
              cnt_q      <= '0;
              state_q    <= ST_FILL;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {line_tag_q, line_set_q, {LINE_ADDR_LEN{1'b0}}, 2'b00};
            end else begin
              cnt_q       <= cnt_d;
              mem_addr_q  <= {ls_tag, line_set_q, cnt_d, 2'b00};
              mem_wdata_q <= ls_wb_word;
            end
          end
        end
        ST_FILL: begin
          if (ack) begin
            if (last) begin
              cnt_q     <= '0;
              state_q   <= ST_IDLE;
              mem_req_q <= 1'b0;
            end else begin
              cnt_q      <= cnt_d;
              mem_addr_q <= {line_tag_q, line_set_q, cnt_d, 2'b00};
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_PERF_CNT_EN
  logic        replay_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating hit/miss counters; the replayed hit right after a fill is skipped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      replay_q <= (state_q == ST_FILL) && ack && last;
      if ((state_q == ST_IDLE) && req) begin
        if (hit) begin
          if (!replay_q && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_q <= hit_cnt_q + 32'd1;
        end else if (miss_cnt_q != 32'hFFFF_FFFF) begin
          miss_cnt_q <= miss_cnt_q + 32'd1;
        end
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
